// File: rtl/pong_pkg.sv
// Shared state encoding, score limit and BCD score conversion for the Pong match controller.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_NEWGAME = 3'd0,
    ST_SERVE   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_CHECK   = 3'd3,
    ST_OVER    = 3'd4
  } state_t;

  localparam logic [6:0] MAX_SCORE = 7'd99;

  function automatic logic [6:0] bcd_to_bin(input logic [3:0] d1, input logic [3:0] d0);
    logic [6:0] v;
    v = 7'(d1) * 7'd10 + 7'(d0);
    return v;
  endfunction

endpackage

// File: rtl/pong_score_ctrl_if.sv
// Score-path bundle between the match controller and collision logic, counters and overlay.
interface pong_score_ctrl_if;
  logic       tick;
  logic       btn_start;
  logic       miss_left;
  logic       miss_right;
  logic [3:0] l_dig1;
  logic [3:0] l_dig0;
  logic [3:0] r_dig1;
  logic [3:0] r_dig0;
  logic       inc_left;
  logic       inc_right;
  logic       clr;
  logic       ball_still;
  logic       game_over;
  logic       winner;
  logic [2:0] state_o;

  modport master (
    input  tick, btn_start, miss_left, miss_right,
    input  l_dig1, l_dig0, r_dig1, r_dig0,
    output inc_left, inc_right, clr, ball_still, game_over, winner, state_o
  );

  modport slave (
    output tick, btn_start, miss_left, miss_right,
    output l_dig1, l_dig0, r_dig1, r_dig0,
    input  inc_left, inc_right, clr, ball_still, game_over, winner, state_o
  );
endinterface

// File: rtl/pong_serve_timer.sv
// Serve delay: loadable down-counter stepped by the frame tick with a zero flag.
// Load takes priority over tick; the count holds at zero; no backpressure.
module pong_serve_timer #(
  parameter int SERVE_TICKS = 120,
  parameter int TW          = $clog2(SERVE_TICKS + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic zero
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(SERVE_TICKS);
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pong_score_ctrl.sv
// Pong match FSM: owns score increment/clear strobes, serve delay, win detection; all outputs registered.
// Build with WIN_BY_TWO_EN defined to require a two-point lead for a win.
module pong_score_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 120
) (
  input logic              clk,
  input logic              reset,
  pong_score_ctrl_if.master bus
);

  localparam int         TW      = $clog2(SERVE_TICKS + 1);
  localparam logic [6:0] WIN_BIN = 7'(WIN_SCORE);

  state_t     state_q, state_nx;
  logic       check_ph_q, check_ph_nx;
  logic       sat_q, sat_nx;
  logic       scorer_q, scorer_nx;
  logic       armed_q, armed_nx;
  logic       winner_q, winner_nx;
  logic       inc_left_q, inc_left_nx;
  logic       inc_right_q, inc_right_nx;
  logic       clr_q, ball_still_q, game_over_q;
  logic       timer_load, timer_zero;
  logic [6:0] l_score, r_score;
  logic       left_wins, right_wins;

  assign l_score = bcd_to_bin(bus.l_dig1, bus.l_dig0);
  assign r_score = bcd_to_bin(bus.r_dig1, bus.r_dig0);

`ifdef WIN_BY_TWO_EN
  assign left_wins  = (l_score >= WIN_BIN) && ({1'b0, l_score} >= {1'b0, r_score} + 8'd2);
  assign right_wins = (r_score >= WIN_BIN) && ({1'b0, r_score} >= {1'b0, l_score} + 8'd2);
`else
  assign left_wins  = (l_score >= WIN_BIN);
  assign right_wins = (r_score >= WIN_BIN);
`endif

  pong_serve_timer #(
    .SERVE_TICKS(SERVE_TICKS),
    .TW         (TW)
  ) u_serve_timer (
    .clk  (clk),
    .reset(reset),
    .load (timer_load),
    .tick (bus.tick),
    .zero (timer_zero)
  );

  always_comb begin
    state_nx     = state_q;
    check_ph_nx  = 1'b0;
    sat_nx       = sat_q;
    scorer_nx    = scorer_q;
    armed_nx     = 1'b0;
    winner_nx    = winner_q;
    inc_left_nx  = 1'b0;
    inc_right_nx = 1'b0;
    timer_load   = 1'b0;

    case (state_q)
      ST_NEWGAME: begin
        if (bus.btn_start) begin
          state_nx   = ST_SERVE;
          timer_load = 1'b1;
        end
      end

      ST_SERVE: begin
        if (timer_zero) begin
          state_nx = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (bus.miss_left && bus.miss_right) begin
          state_nx   = ST_SERVE;
          timer_load = 1'b1;
        end else if (bus.miss_right) begin
          // A point on a saturated counter is remembered instead of issued.
          state_nx    = ST_CHECK;
          scorer_nx   = 1'b0;
          sat_nx      = (l_score >= MAX_SCORE);
          inc_left_nx = (l_score < MAX_SCORE);
        end else if (bus.miss_left) begin
          state_nx     = ST_CHECK;
          scorer_nx    = 1'b1;
          sat_nx       = (r_score >= MAX_SCORE);
          inc_right_nx = (r_score < MAX_SCORE);
        end
      end

      ST_CHECK: begin
        // First cycle waits for the counter to absorb the increment.
        if (!check_ph_q) begin
          check_ph_nx = 1'b1;
        end else if (sat_q) begin
          state_nx  = ST_OVER;
          winner_nx = scorer_q;
        end else if (left_wins) begin
          state_nx  = ST_OVER;
          winner_nx = 1'b0;
        end else if (right_wins) begin
          state_nx  = ST_OVER;
          winner_nx = 1'b1;
        end else begin
          state_nx   = ST_SERVE;
          timer_load = 1'b1;
        end
      end

      ST_OVER: begin
        armed_nx = armed_q | ~bus.btn_start;
        if (armed_q && bus.btn_start) begin
          state_nx = ST_NEWGAME;
        end
      end

      default: begin
        state_nx = ST_NEWGAME;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_NEWGAME;
      check_ph_q   <= 1'b0;
      sat_q        <= 1'b0;
      scorer_q     <= 1'b0;
      armed_q      <= 1'b0;
      winner_q     <= 1'b0;
      inc_left_q   <= 1'b0;
      inc_right_q  <= 1'b0;
      clr_q        <= 1'b1;
      ball_still_q <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_nx;
      check_ph_q   <= check_ph_nx;
      sat_q        <= sat_nx;
      scorer_q     <= scorer_nx;
      armed_q      <= armed_nx;
      winner_q     <= winner_nx;
      inc_left_q   <= inc_left_nx;
      inc_right_q  <= inc_right_nx;
      clr_q        <= (state_nx == ST_NEWGAME);
      ball_still_q <= (state_nx != ST_PLAY);
      game_over_q  <= (state_nx == ST_OVER);
    end
  end

  assign bus.inc_left   = inc_left_q;
  assign bus.inc_right  = inc_right_q;
  assign bus.clr        = clr_q;
  assign bus.ball_still = ball_still_q;
  assign bus.game_over  = game_over_q;
  assign bus.winner     = winner_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Self-checking bench for pong_score_ctrl with behavioural BCD score counters and an increment scoreboard.
module tb_pong_score_ctrl;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_score_ctrl_if bus();

  pong_score_ctrl #(.WIN_SCORE(7), .SERVE_TICKS(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  bit exp_q[$];   // expected increment side: 0 = left, 1 = right
  bit inc_prev;

  // Score counters as the environment supplies them, with a preload for reaching boundary scores.
  logic [3:0] l1, l0, r1, r0;
  logic       pre_en;
  logic [7:0] pre_l, pre_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l1 <= 4'd0; l0 <= 4'd0; r1 <= 4'd0; r0 <= 4'd0;
    end else if (pre_en) begin
      {l1, l0} <= pre_l;
      {r1, r0} <= pre_r;
    end else if (bus.clr) begin
      l1 <= 4'd0; l0 <= 4'd0; r1 <= 4'd0; r0 <= 4'd0;
    end else begin
      if (bus.inc_left && ({l1, l0} != 8'h99)) begin
        if (l0 == 4'd9) begin l0 <= 4'd0; l1 <= l1 + 4'd1; end
        else l0 <= l0 + 4'd1;
      end
      if (bus.inc_right && ({r1, r0} != 8'h99)) begin
        if (r0 == 4'd9) begin r0 <= 4'd0; r1 <= r1 + 4'd1; end
        else r0 <= r0 + 4'd1;
      end
    end
  end

  assign bus.l_dig1 = l1;
  assign bus.l_dig0 = l0;
  assign bus.r_dig1 = r1;
  assign bus.r_dig0 = r0;

  // Scoreboard side: every increment pulse must match the next expected point.
  always @(negedge clk) begin
    if (reset) begin
      inc_prev = 1'b0;
    end else begin
      if (bus.inc_left || bus.inc_right) begin
        total++;
        if (bus.inc_left && bus.inc_right) begin
          bad++; $display("FAIL inc_both: inc_left=%0b inc_right=%0b want one-hot", bus.inc_left, bus.inc_right);
        end else if (bus.clr) begin
          bad++; $display("FAIL inc_with_clr: clr=%0b want 0 during increment", bus.clr);
        end else if (inc_prev) begin
          bad++; $display("FAIL inc_width: increment high 2 cycles, want 1");
        end else if (exp_q.size() == 0) begin
          bad++; $display("FAIL inc_unexpected: got side %0d want no increment", bus.inc_right);
        end else begin
          bit e;
          e = exp_q.pop_front();
          if (bus.inc_right !== e) begin
            bad++; $display("FAIL inc_side: got side %0d want %0d", bus.inc_right, e);
          end
        end
      end
      inc_prev = bus.inc_left | bus.inc_right;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_tick();
    bus.tick = 1'b1; cyc(1); bus.tick = 1'b0; cyc(1);
  endtask

  task automatic serve_to_play();
    repeat (3) do_tick();
  endtask

  task automatic miss(input bit ml, input bit mr);
    bus.miss_left = ml; bus.miss_right = mr; cyc(1);
    bus.miss_left = 1'b0; bus.miss_right = 1'b0;
  endtask

  task automatic preload(input logic [7:0] l, input logic [7:0] r);
    pre_l = l; pre_r = r; pre_en = 1'b1; cyc(1); pre_en = 1'b0;
  endtask

  task automatic restart();
    bus.btn_start = 1'b0; cyc(1); bus.btn_start = 1'b1; cyc(2); bus.btn_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc(2);
    total++; if (bus.state_o !== ST_NEWGAME) begin bad++; $display("FAIL rst_state: got %0d want %0d", bus.state_o, ST_NEWGAME); end
    total++; if (bus.clr !== 1'b1) begin bad++; $display("FAIL rst_clr: got %0b want 1", bus.clr); end
    total++; if (bus.ball_still !== 1'b1) begin bad++; $display("FAIL rst_ball_still: got %0b want 1", bus.ball_still); end
    total++; if (bus.game_over !== 1'b0 || bus.winner !== 1'b0) begin bad++; $display("FAIL rst_over: got %0b/%0b want 0/0", bus.game_over, bus.winner); end
    total++; if (bus.inc_left !== 1'b0 || bus.inc_right !== 1'b0) begin bad++; $display("FAIL rst_inc: got %0b/%0b want 0/0", bus.inc_left, bus.inc_right); end
    reset = 1'b0; cyc(2);
    total++; if (bus.state_o !== ST_NEWGAME) begin bad++; $display("FAIL idle_newgame: got %0d want %0d", bus.state_o, ST_NEWGAME); end
  endtask

  task automatic test_start();
    bus.btn_start = 1'b1; cyc(1); bus.btn_start = 1'b0;
    total++; if (bus.state_o !== ST_SERVE) begin bad++; $display("FAIL start_state: got %0d want %0d", bus.state_o, ST_SERVE); end
    total++; if (bus.clr !== 1'b0) begin bad++; $display("FAIL start_clr_drop: got %0b want 0", bus.clr); end
    repeat (2) do_tick();
    total++; if (bus.state_o !== ST_SERVE || bus.ball_still !== 1'b1) begin bad++; $display("FAIL serve_hold: got %0d/%0b want %0d/1", bus.state_o, bus.ball_still, ST_SERVE); end
    do_tick();
    total++; if (bus.state_o !== ST_PLAY || bus.ball_still !== 1'b0) begin bad++; $display("FAIL serve_to_play: got %0d/%0b want %0d/0", bus.state_o, bus.ball_still, ST_PLAY); end
  endtask

  task automatic test_point_left();
    exp_q.push_back(1'b0);
    miss(1'b0, 1'b1);
    total++; if (bus.state_o !== ST_CHECK || bus.inc_left !== 1'b1) begin bad++; $display("FAIL pl_check: got %0d/%0b want %0d/1", bus.state_o, bus.inc_left, ST_CHECK); end
    cyc(1);
    total++; if (bus.inc_left !== 1'b0) begin bad++; $display("FAIL pl_inc_drop: got %0b want 0", bus.inc_left); end
    cyc(1);
    total++; if (bus.state_o !== ST_SERVE || bus.ball_still !== 1'b1) begin bad++; $display("FAIL pl_serve: got %0d/%0b want %0d/1", bus.state_o, bus.ball_still, ST_SERVE); end
    total++; if ({l1, l0, r1, r0} !== 16'h0100) begin bad++; $display("FAIL pl_score: got %h want 0100", {l1, l0, r1, r0}); end
    // misses and start presses during the serve delay change nothing
    miss(1'b0, 1'b1); bus.btn_start = 1'b1; cyc(1); bus.btn_start = 1'b0;
    total++; if (bus.state_o !== ST_SERVE) begin bad++; $display("FAIL serve_ignore: got %0d want %0d", bus.state_o, ST_SERVE); end
    serve_to_play();
    total++; if (bus.state_o !== ST_PLAY) begin bad++; $display("FAIL pl_replay_play: got %0d want %0d", bus.state_o, ST_PLAY); end
  endtask

  task automatic test_point_right();
    exp_q.push_back(1'b1);
    miss(1'b1, 1'b0); cyc(2);
    total++; if (bus.state_o !== ST_SERVE) begin bad++; $display("FAIL pr_serve: got %0d want %0d", bus.state_o, ST_SERVE); end
    total++; if ({l1, l0, r1, r0} !== 16'h0101) begin bad++; $display("FAIL pr_score: got %h want 0101", {l1, l0, r1, r0}); end
  endtask

  task automatic test_both_miss();
    serve_to_play();
    miss(1'b1, 1'b1);
    total++; if (bus.state_o !== ST_SERVE || bus.ball_still !== 1'b1) begin bad++; $display("FAIL both_serve: got %0d/%0b want %0d/1", bus.state_o, bus.ball_still, ST_SERVE); end
    cyc(2);
    total++; if ({l1, l0, r1, r0} !== 16'h0101) begin bad++; $display("FAIL both_score: got %h want 0101", {l1, l0, r1, r0}); end
    repeat (2) do_tick();
    total++; if (bus.state_o !== ST_SERVE) begin bad++; $display("FAIL both_reload: got %0d want %0d", bus.state_o, ST_SERVE); end
    do_tick();
    total++; if (bus.state_o !== ST_PLAY) begin bad++; $display("FAIL both_play: got %0d want %0d", bus.state_o, ST_PLAY); end
  endtask

  task automatic test_win_left();
    preload(8'h06, 8'h01);
    bus.btn_start = 1'b1;
    exp_q.push_back(1'b0);
    miss(1'b0, 1'b1); cyc(2);
    total++; if (bus.state_o !== ST_OVER || bus.game_over !== 1'b1 || bus.winner !== 1'b0) begin bad++; $display("FAIL wl_over: got %0d/%0b/%0b want %0d/1/0", bus.state_o, bus.game_over, bus.winner, ST_OVER); end
    total++; if ({l1, l0} !== 8'h07) begin bad++; $display("FAIL wl_score: got %h want 07", {l1, l0}); end
    miss(1'b0, 1'b1); miss(1'b1, 1'b0); cyc(3);
    total++; if (bus.state_o !== ST_OVER || bus.ball_still !== 1'b1) begin bad++; $display("FAIL wl_hold_btn: got %0d/%0b want %0d/1", bus.state_o, bus.ball_still, ST_OVER); end
    bus.btn_start = 1'b0; cyc(1); bus.btn_start = 1'b1; cyc(1);
    total++; if (bus.state_o !== ST_NEWGAME || bus.clr !== 1'b1 || bus.game_over !== 1'b0) begin bad++; $display("FAIL wl_newgame: got %0d/%0b/%0b want %0d/1/0", bus.state_o, bus.clr, bus.game_over, ST_NEWGAME); end
    cyc(1); bus.btn_start = 1'b0;
    total++; if (bus.state_o !== ST_SERVE || bus.clr !== 1'b0) begin bad++; $display("FAIL wl_reserve: got %0d/%0b want %0d/0", bus.state_o, bus.clr, ST_SERVE); end
    total++; if ({l1, l0, r1, r0} !== 16'h0000) begin bad++; $display("FAIL wl_cleared: got %h want 0000", {l1, l0, r1, r0}); end
  endtask

  task automatic test_win_right();
    serve_to_play();
    preload(8'h02, 8'h06);
    exp_q.push_back(1'b1);
    miss(1'b1, 1'b0); cyc(2);
    total++; if (bus.state_o !== ST_OVER || bus.winner !== 1'b1) begin bad++; $display("FAIL wr_over: got %0d/%0b want %0d/1", bus.state_o, bus.winner, ST_OVER); end
    total++; if ({r1, r0} !== 8'h07) begin bad++; $display("FAIL wr_score: got %h want 07", {r1, r0}); end
    restart();
    total++; if (bus.state_o !== ST_SERVE) begin bad++; $display("FAIL wr_restart: got %0d want %0d", bus.state_o, ST_SERVE); end
  endtask

  task automatic test_saturation();
    serve_to_play();
    preload(8'h99, 8'h00);
    miss(1'b0, 1'b1);
    total++; if (bus.inc_left !== 1'b0) begin bad++; $display("FAIL sat_no_inc: got %0b want 0", bus.inc_left); end
    cyc(2);
    total++; if (bus.state_o !== ST_OVER || bus.winner !== 1'b0) begin bad++; $display("FAIL sat_over: got %0d/%0b want %0d/0", bus.state_o, bus.winner, ST_OVER); end
    total++; if ({l1, l0} !== 8'h99) begin bad++; $display("FAIL sat_score: got %h want 99", {l1, l0}); end
    restart();
    serve_to_play();
    preload(8'h03, 8'h99);
    miss(1'b1, 1'b0); cyc(2);
    total++; if (bus.state_o !== ST_OVER || bus.winner !== 1'b1) begin bad++; $display("FAIL sat_r_over: got %0d/%0b want %0d/1", bus.state_o, bus.winner, ST_OVER); end
    restart();
  endtask

  task automatic test_win_by_two();
    serve_to_play();
    preload(8'h06, 8'h06);
    exp_q.push_back(1'b0);
    miss(1'b0, 1'b1); cyc(2);
`ifdef WIN_BY_TWO_EN
    total++; if (bus.state_o !== ST_SERVE || bus.game_over !== 1'b0) begin bad++; $display("FAIL w2_no_win: got %0d/%0b want %0d/0", bus.state_o, bus.game_over, ST_SERVE); end
    serve_to_play();
    exp_q.push_back(1'b0);
    miss(1'b0, 1'b1); cyc(2);
    total++; if (bus.state_o !== ST_OVER || bus.game_over !== 1'b1 || bus.winner !== 1'b0) begin bad++; $display("FAIL w2_win: got %0d/%0b/%0b want %0d/1/0", bus.state_o, bus.game_over, bus.winner, ST_OVER); end
    total++; if ({l1, l0} !== 8'h08) begin bad++; $display("FAIL w2_score: got %h want 08", {l1, l0}); end
`else
    total++; if (bus.state_o !== ST_OVER || bus.game_over !== 1'b1 || bus.winner !== 1'b0) begin bad++; $display("FAIL w1_win: got %0d/%0b/%0b want %0d/1/0", bus.state_o, bus.game_over, bus.winner, ST_OVER); end
    total++; if ({l1, l0} !== 8'h07) begin bad++; $display("FAIL w1_score: got %h want 07", {l1, l0}); end
`endif
    restart();
  endtask

  task automatic test_reset_mid_rally();
    serve_to_play();
    total++; if (bus.state_o !== ST_PLAY) begin bad++; $display("FAIL mr_play: got %0d want %0d", bus.state_o, ST_PLAY); end
    reset = 1'b1; #1;
    total++; if (bus.state_o !== ST_NEWGAME || bus.clr !== 1'b1 || bus.ball_still !== 1'b1) begin bad++; $display("FAIL mr_reset: got %0d/%0b/%0b want %0d/1/1", bus.state_o, bus.clr, bus.ball_still, ST_NEWGAME); end
    cyc(1); reset = 1'b0; cyc(1);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1;
    pre_en = 1'b0; pre_l = 8'h00; pre_r = 8'h00;
    bus.tick = 1'b0; bus.btn_start = 1'b0;
    bus.miss_left = 1'b0; bus.miss_right = 1'b0;
    test_reset();
    test_start();
    test_point_left();
    test_point_right();
    test_both_miss();
    test_win_left();
    test_win_right();
    test_saturation();
    test_win_by_two();
    test_reset_mid_rally();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
